// File: rtl/vga_top.sv
`timescale 1ns/1ps
// vga_top: 640x480@60 Hz VGA timing generator with a moving square sprite.
//
// Ports
//   HCLK        in   50 MHz system clock, rising edge, the only clock
//   HRESETn     in   asynchronous active-low reset
//   button      in   push button, active-low, asynchronous to HCLK
//   VGA_R/G/B   out  8-bit pixel colour (0 when blanked)
//   VGA_HS/VS   out  horizontal / vertical sync, active-low
//   VGA_CLK     out  25 MHz pixel clock (HCLK/2)
//   VGA_BLANK_N out  1 inside the active video area
//
// All video outputs are registered on the pixel enable, so they lag the
// hcount/vcount counters by exactly one pixel. The sprite moves STEP pixels
// per frame in the current direction; each button press rotates the
// direction right -> down -> left -> up -> right.
module vga_top #(
  parameter int SPRITE_SIZE = 16,
  parameter int STEP        = 1,
  parameter int BORDER      = 8
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       button,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_CLK,
  output logic       VGA_BLANK_N
);

  localparam logic [9:0]  H_ACTIVE     = 10'd640;
  localparam logic [9:0]  H_SYNC_FIRST = 10'd656;
  localparam logic [9:0]  H_SYNC_LAST  = 10'd751;
  localparam logic [9:0]  H_LAST       = 10'd799;
  localparam logic [9:0]  V_ACTIVE     = 10'd480;
  localparam logic [9:0]  V_SYNC_FIRST = 10'd490;
  localparam logic [9:0]  V_SYNC_LAST  = 10'd491;
  localparam logic [9:0]  V_LAST       = 10'd524;
  // Number of legal sprite positions per axis (0..624 and 0..464).
  localparam logic [10:0] X_SPAN       = 11'(640 - SPRITE_SIZE + 1);
  localparam logic [10:0] Y_SPAN       = 11'(480 - SPRITE_SIZE + 1);
  localparam logic [9:0]  X_RESET      = 10'd312;
  localparam logic [8:0]  Y_RESET      = 9'd232;
  localparam logic [9:0]  BORDER_LO    = 10'(BORDER);
  localparam logic [9:0]  BORDER_RIGHT = 10'(640 - BORDER);
  localparam logic [9:0]  BORDER_BOT   = 10'(480 - BORDER);
  localparam logic [10:0] SIZE11       = 11'(SPRITE_SIZE);
  localparam logic [10:0] STEP11       = 11'(STEP);

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_UP    = 2'd3
  } dir_t;

  logic       vclk_q;
  logic       pix_en;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic [9:0] pos_x;
  logic [8:0] pos_y;
  dir_t       dir;
  logic       b_meta;
  logic       b_sync;
  logic       b_prev;
  logic       press;
  logic       frame_tick;
  logic [9:0] x_next;
  logic [8:0] y_next;
  logic       active;
  logic       in_sprite;
  logic       in_border;

  // Pixel enable fires on the edge where the divided clock falls 1->0.
  assign VGA_CLK    = vclk_q;
  assign pix_en     = vclk_q;
  assign press      = b_prev & ~b_sync;
  assign frame_tick = pix_en && (hcount == 10'd0) && (vcount == V_ACTIVE);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      vclk_q <= 1'b0;
      hcount <= 10'd0;
      vcount <= 10'd0;
    end else begin
      vclk_q <= ~vclk_q;
      if (pix_en) begin
        if (hcount == H_LAST) begin
          hcount <= 10'd0;
          vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
        end else begin
          hcount <= hcount + 10'd1;
        end
      end
    end
  end

  // Next position one STEP along the current direction, wrapping modulo
  // the number of legal positions on that axis.
  always_comb begin
    x_next = pos_x;
    y_next = pos_y;
    case (dir)
      DIR_RIGHT: x_next = ({1'b0, pos_x} + STEP11 >= X_SPAN)
                          ? 10'({1'b0, pos_x} + STEP11 - X_SPAN)
                          : 10'({1'b0, pos_x} + STEP11);
      DIR_DOWN:  y_next = ({2'b0, pos_y} + STEP11 >= Y_SPAN)
                          ? 9'({2'b0, pos_y} + STEP11 - Y_SPAN)
                          : 9'({2'b0, pos_y} + STEP11);
      DIR_LEFT:  x_next = ({1'b0, pos_x} >= STEP11)
                          ? 10'({1'b0, pos_x} - STEP11)
                          : 10'({1'b0, pos_x} + X_SPAN - STEP11);
      DIR_UP:    y_next = ({2'b0, pos_y} >= STEP11)
                          ? 9'({2'b0, pos_y} - STEP11)
                          : 9'({2'b0, pos_y} + Y_SPAN - STEP11);
      default:   ;
    endcase
  end

  // Synchronizer flops reset to 1 (released). A button level that is not
  // a clean 0 (including X before the pin is first driven) counts as released.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      b_meta <= 1'b1;
      b_sync <= 1'b1;
      b_prev <= 1'b1;
      pos_x  <= X_RESET;
      pos_y  <= Y_RESET;
      dir    <= DIR_RIGHT;
    end else begin
      b_meta <= (button !== 1'b0);
      b_sync <= b_meta;
      b_prev <= b_sync;
      // The move uses the direction held before any same-edge press.
      if (frame_tick) begin
        pos_x <= x_next;
        pos_y <= y_next;
      end
      if (press) dir <= dir_t'(dir + 2'd1);
    end
  end

  always_comb begin
    active    = (hcount < H_ACTIVE) && (vcount < V_ACTIVE);
    in_sprite = ({1'b0, hcount} >= {1'b0, pos_x}) &&
                ({1'b0, hcount} <  {1'b0, pos_x} + SIZE11) &&
                ({1'b0, vcount} >= {2'b0, pos_y}) &&
                ({1'b0, vcount} <  {2'b0, pos_y} + SIZE11);
    in_border = (hcount < BORDER_LO) || (hcount >= BORDER_RIGHT) ||
                (vcount < BORDER_LO) || (vcount >= BORDER_BOT);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= 8'h00;
      VGA_G       <= 8'h00;
      VGA_B       <= 8'h00;
    end else if (pix_en) begin
      VGA_HS      <= !((hcount >= H_SYNC_FIRST) && (hcount <= H_SYNC_LAST));
      VGA_VS      <= !((vcount >= V_SYNC_FIRST) && (vcount <= V_SYNC_LAST));
      VGA_BLANK_N <= active;
      if (!active) begin
        {VGA_R, VGA_G, VGA_B} <= 24'h000000;
      end else if (in_sprite) begin
        {VGA_R, VGA_G, VGA_B} <= 24'hFFFF00;
      end else if (in_border) begin
        {VGA_R, VGA_G, VGA_B} <= 24'h0000FF;
      end else begin
        {VGA_R, VGA_G, VGA_B} <= 24'h000000;
      end
    end
  end

endmodule

// File: tb/tb_vga_top.sv
`timescale 1ns/1ps
// tb_vga_top: checks vga_top pixel by pixel against a coordinate-level
// model of the VGA raster, sprite motion and button rotation. Long vertical
// stretches are skipped by jumping the line counter (and, for wrap cases,
// the sprite position); the model is told the same jump values.
module tb_vga_top;

  localparam int SPRITE_SIZE = 16;
  localparam int STEP        = 1;
  localparam int BORDER      = 8;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic       button;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic       VGA_HS, VGA_VS, VGA_CLK, VGA_BLANK_N;

  vga_top #(
    .SPRITE_SIZE(SPRITE_SIZE),
    .STEP       (STEP),
    .BORDER     (BORDER)
  ) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .button     (button),
    .VGA_R      (VGA_R),
    .VGA_G      (VGA_G),
    .VGA_B      (VGA_B),
    .VGA_HS     (VGA_HS),
    .VGA_VS     (VGA_VS),
    .VGA_CLK    (VGA_CLK),
    .VGA_BLANK_N(VGA_BLANK_N)
  );

  // ---------------- clock / reset ----------------
  always #10 HCLK = ~HCLK;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [26:0] exp_q[$];
  bit          done = 1'b0;

  // Reference model: next pixel coordinate to be shown, sprite position
  // and direction, and HCLK edges seen since reset release.
  int edge_n, nh, nv, mx, my, mdir;

  logic [9:0] force_v;
  logic [9:0] force_x;
  logic [8:0] force_y;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Expected {R,G,B,HS,VS,BLANK_N} for raster point (h,v) with the sprite at (x,y).
  function automatic logic [26:0] expected_pixel(input int h, input int v, input int x, input int y);
    logic [23:0] rgb;
    logic        act, hs, vs;
    act = (h < 640) && (v < 480);
    hs  = !(h >= 656 && h <= 751);
    vs  = !(v >= 490 && v <= 491);
    if (!act) rgb = 24'h000000;
    else if (h >= x && h < x + SPRITE_SIZE && v >= y && v < y + SPRITE_SIZE) rgb = 24'hFFFF00;
    else if (h < BORDER || h >= 640 - BORDER || v < BORDER || v >= 480 - BORDER) rgb = 24'h0000FF;
    else rgb = 24'h000000;
    return {rgb, hs, vs, act};
  endfunction

  // ---------------- model + monitor ----------------
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      edge_n = 0;
      nh     = 0;
      nv     = 0;
      mx     = 312;
      my     = 232;
      mdir   = 0;
      exp_q.delete();
    end else if (!done) begin
      edge_n++;
      check("vga_clk", 32'(VGA_CLK), 32'(edge_n % 2));
      // Every second HCLK edge presents one new pixel.
      if (edge_n % 2 == 0) begin
        exp_q.push_back(expected_pixel(nh, nv, mx, my));
        check($sformatf("pixel h=%0d v=%0d", nh, nv),
              32'({VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N}),
              32'(exp_q.pop_front()));
        if (nh == 0 && nv == 480) begin
          case (mdir)
            0:       mx = (mx + STEP) % 625;
            1:       my = (my + STEP) % 465;
            2:       mx = (mx - STEP + 625) % 625;
            default: my = (my - STEP + 465) % 465;
          endcase
        end
        nh++;
        if (nh == 800) begin
          nh = 0;
          nv = (nv + 1) % 525;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run(input int cycles);
    repeat (cycles) @(negedge HCLK);
  endtask

  task automatic do_reset();
    @(negedge HCLK);
    #2 HRESETn = 1'b0;
    #1;
    check("rst_hs",      32'(VGA_HS), 32'd1);
    check("rst_vs",      32'(VGA_VS), 32'd1);
    check("rst_blank_n", 32'(VGA_BLANK_N), 32'd0);
    check("rst_rgb",     32'({VGA_R, VGA_G, VGA_B}), 32'd0);
    check("rst_vga_clk", 32'(VGA_CLK), 32'd0);
    run(4);
    #2 HRESETn = 1'b1;
  endtask

  task automatic jump_line(input int v);
    @(negedge HCLK);
    #2;
    force_v = 10'(v);
    force dut.vcount = force_v;
    nv = v;
    #1 release dut.vcount;
  endtask

  task automatic set_pos(input int x, input int y);
    @(negedge HCLK);
    #2;
    force_x = 10'(x);
    force_y = 9'(y);
    force dut.pos_x = force_x;
    force dut.pos_y = force_y;
    mx = x;
    my = y;
    #1;
    release dut.pos_x;
    release dut.pos_y;
  endtask

  task automatic press(input int width);
    @(negedge HCLK);
    #2 button = 1'b0;
    mdir = (mdir + 1) % 4;
    repeat (width) @(negedge HCLK);
    #2 button = 1'b1;
    run(6);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int np;
    int sel;
    button  = 1'b1;
    HRESETn = 1'b0;
    do_reset();

    // Frame 0: first line, a background row, the sprite centre row.
    run(1700);
    jump_line(99);  run(1700);
    jump_line(239); run(1700);

    // Short press -> down; frame update; vertical sync region; frame 1.
    press(3);
    jump_line(478); run(3300);
    jump_line(489); run(3500);
    jump_line(524); run(1700);
    jump_line(232); run(2400);

    // Second press -> left, next frame moves x back by one.
    press(3);
    jump_line(478); run(3300);
    jump_line(232); run(2400);

    // Mid-frame reset, then right-edge wrap from x=624.
    run(300);
    do_reset();
    run(2400);
    set_pos(624, 232);
    jump_line(478); run(3300);
    jump_line(232); run(2400);

    // Randomized presses (short and held) and edge/random positions.
    for (int r = 0; r < 4; r++) begin
      np = $urandom_range(0, 2);
      for (int k = 0; k < np; k++) press($urandom_range(3, 40));
      sel = $urandom_range(0, 2);
      if (sel == 1)
        set_pos($urandom_range(0, 1) ? 624 : 0, $urandom_range(0, 1) ? 464 : 0);
      else if (sel == 2)
        set_pos($urandom_range(0, 624), $urandom_range(0, 464));
      jump_line(478); run(3300);
      jump_line(my);  run(2400);
    end

    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
